// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch state encoding, reset/NOP defaults and
// word-address helpers used by the instruction-fetch front end.
package pipeline_pkg;

    localparam int unsigned WORD_BYTES        = 4;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async reset to the boot address, with a
// word-aligned load (redirect) that takes priority over a +4 increment.
module pc_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_next
);

    // pc_next is exported so the fetch FSM can register the next request
    // address in the same cycle the PC itself is updated.
    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = word_align(target);
        end else if (inc) begin
            pc_next = next_word(pc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives a variable-latency
// instruction memory and holds one fetched word for the IF/ID register.
module if_fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ready,
    input  logic [31:0] IMem_RData,
    output logic [31:0] IF_PCplusFour,
    output logic [31:0] IF_Instruction,
    output logic        IF_Valid,
    output logic        Fetch_Stall
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic         pc_load;
    logic         pc_inc;
    logic [31:0]  addr_hold;
    logic [31:0]  instr_buf;
    logic [31:0]  pc_plus4_buf;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (BranchTarget),
        .pc     (pc),
        .pc_next(pc_next)
    );

    // A redirect always wins over consumption; PCWrite only matters while
    // an instruction is actually being held.
    always_comb begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        case (state)
            FETCH, DISCARD: pc_load = PCSrc;
            HOLD: begin
                pc_load = PCSrc;
                pc_inc  = !PCSrc && PCWrite;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            addr_hold    <= RESET_PC;
            instr_buf    <= NOP_INSTR;
            pc_plus4_buf <= 32'h0;
            IMem_Req     <= 1'b0;
            IMem_Addr    <= RESET_PC;
            IF_Valid     <= 1'b0;
            Fetch_Stall  <= 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    state     <= FETCH;
                    IMem_Req  <= 1'b1;
                    IMem_Addr <= pc;
                end
                FETCH: begin
                    if (PCSrc && IMem_Ready) begin
                        IMem_Addr <= pc_next;
                    end else if (PCSrc) begin
                        // The memory still owns the old address; park it so
                        // the request can complete unchanged and be dropped.
                        addr_hold <= pc;
                        IMem_Addr <= pc;
                        state     <= DISCARD;
                    end else if (IMem_Ready) begin
                        instr_buf    <= IMem_RData;
                        pc_plus4_buf <= next_word(pc);
                        IMem_Req     <= 1'b0;
                        IF_Valid     <= 1'b1;
                        Fetch_Stall  <= 1'b0;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (PCSrc || PCWrite) begin
                        instr_buf    <= NOP_INSTR;
                        pc_plus4_buf <= 32'h0;
                        IMem_Req     <= 1'b1;
                        IMem_Addr    <= pc_next;
                        IF_Valid     <= 1'b0;
                        Fetch_Stall  <= 1'b1;
                        state        <= FETCH;
                    end
                end
                DISCARD: begin
                    if (IMem_Ready) begin
                        IMem_Addr <= pc_next;
                        state     <= FETCH;
                    end else begin
                        IMem_Addr <= addr_hold;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    assign IF_Instruction = instr_buf;
    assign IF_PCplusFour  = pc_plus4_buf;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: vector table, directed corner
// sequences and randomized traffic against a request-level reference model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCWrite = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ready = 1'b0;
    logic [31:0] IMem_RData = 32'h0;
    logic [31:0] IF_PCplusFour;
    logic [31:0] IF_Instruction;
    logic        IF_Valid;
    logic        Fetch_Stall;

    int n_compared = 0;
    int n_mismatched = 0;

    if_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PCWrite       (PCWrite),
        .PCSrc         (PCSrc),
        .BranchTarget  (BranchTarget),
        .IMem_Req      (IMem_Req),
        .IMem_Addr     (IMem_Addr),
        .IMem_Ready    (IMem_Ready),
        .IMem_RData    (IMem_RData),
        .IF_PCplusFour (IF_PCplusFour),
        .IF_Instruction(IF_Instruction),
        .IF_Valid      (IF_Valid),
        .Fetch_Stall   (Fetch_Stall)
    );

    always #5 clk = ~clk;

    // Reference model in terms of the memory transaction: is a request
    // outstanding, to which address, and will its data be thrown away.
    bit          m_boot;
    bit          m_req;
    bit          m_drop;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_req_addr;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;

    task automatic model_reset();
        m_boot = 1'b1;
        m_req = 1'b0;
        m_drop = 1'b0;
        m_valid = 1'b0;
        m_pc = 32'h0;
        m_req_addr = 32'h0;
        m_instr = 32'h0;
        m_pc4 = 32'h0;
    endtask

    task automatic model_step(input bit pcsrc, input bit pcwrite, input bit ready,
                              input logic [31:0] rdata, input logic [31:0] target);
        logic [31:0] t;
        t = target & 32'hFFFF_FFFC;
        if (m_boot) begin
            m_boot = 1'b0;
            m_req = 1'b1;
            m_req_addr = m_pc;
        end else if (m_req) begin
            if (pcsrc) m_pc = t;
            if (ready) begin
                if (m_drop || pcsrc) begin
                    m_drop = 1'b0;
                    m_req_addr = m_pc;
                end else begin
                    m_req = 1'b0;
                    m_valid = 1'b1;
                    m_instr = rdata;
                    m_pc4 = m_req_addr + 32'd4;
                end
            end else if (pcsrc) begin
                m_drop = 1'b1;
            end
        end else if (m_valid && (pcsrc || pcwrite)) begin
            m_pc = pcsrc ? t : m_pc + 32'd4;
            m_valid = 1'b0;
            m_req = 1'b1;
            m_req_addr = m_pc;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input bit e_req, input logic [31:0] e_addr,
                               input bit e_valid, input logic [31:0] e_instr,
                               input logic [31:0] e_pc4);
        check({tag, ".req"}, {31'b0, IMem_Req}, {31'b0, e_req});
        if (e_req) check({tag, ".addr"}, IMem_Addr, e_addr);
        check({tag, ".valid"}, {31'b0, IF_Valid}, {31'b0, e_valid});
        check({tag, ".stall"}, {31'b0, Fetch_Stall}, {31'b0, !e_valid});
        check({tag, ".instr"}, IF_Instruction, e_instr);
        check({tag, ".pc4"}, IF_PCplusFour, e_pc4);
    endtask

    task automatic applyStimulus(input bit pcsrc, input bit pcwrite, input bit ready,
                                 input logic [31:0] rdata, input logic [31:0] target);
        PCSrc = pcsrc;
        PCWrite = pcwrite;
        IMem_Ready = ready;
        IMem_RData = rdata;
        BranchTarget = target;
        model_step(pcsrc, pcwrite, ready, rdata, target);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        PCSrc = 1'b0;
        PCWrite = 1'b0;
        IMem_Ready = 1'b0;
        IMem_RData = 32'h0;
        BranchTarget = 32'h0;
        rst_n = 1'b0;
        @(posedge clk);
        #3;
        checkOutput({tag, ".rst"}, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check({tag, ".rst.addr"}, IMem_Addr, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          pcsrc;
        bit          pcwrite;
        bit          ready;
        logic [31:0] rdata;
        logic [31:0] target;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Row i: inputs driven during cycle i, outputs expected during cycle i.
        vecs[0]  = '{0, 0, 0, 32'h0,         32'h0,     0, 32'h0,   0, 32'h0,         32'h0};
        vecs[1]  = '{0, 0, 1, 32'h2008_0005, 32'h0,     1, 32'h0,   0, 32'h0,         32'h0};
        vecs[2]  = '{0, 1, 0, 32'h0,         32'h0,     0, 32'h0,   1, 32'h2008_0005, 32'h4};
        vecs[3]  = '{0, 0, 1, 32'h1111_1111, 32'h0,     1, 32'h4,   0, 32'h0,         32'h0};
        vecs[4]  = '{0, 1, 0, 32'h0,         32'h0,     0, 32'h0,   1, 32'h1111_1111, 32'h8};
        vecs[5]  = '{0, 0, 1, 32'h2222_2222, 32'h0,     1, 32'h8,   0, 32'h0,         32'h0};
        vecs[6]  = '{1, 1, 0, 32'h0,         32'h100,   0, 32'h0,   1, 32'h2222_2222, 32'hC};
        vecs[7]  = '{0, 0, 0, 32'h0,         32'h0,     1, 32'h100, 0, 32'h0,         32'h0};
        vecs[8]  = '{0, 1, 1, 32'h3333_3333, 32'h0,     1, 32'h100, 0, 32'h0,         32'h0};
        vecs[9]  = '{0, 0, 0, 32'h0,         32'h0,     0, 32'h0,   1, 32'h3333_3333, 32'h104};
        vecs[10] = '{0, 0, 0, 32'h0,         32'h0,     0, 32'h0,   1, 32'h3333_3333, 32'h104};

        do_reset("vec");
        for (int i = 0; i < 11; i++) begin
            checkOutput($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                        vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc4);
            applyStimulus(vecs[i].pcsrc, vecs[i].pcwrite, vecs[i].ready,
                          vecs[i].rdata, vecs[i].target);
        end

        // Three wait states, then a long stall in HOLD.
        do_reset("wait3");
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("wait3.f%0d", k), 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
            applyStimulus(0, 0, k == 3, 32'hCAFE_0001, 32'h0);
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("wait3.h%0d", k), 1'b0, 32'h0, 1'b1, 32'hCAFE_0001, 32'h4);
            applyStimulus(0, 0, 0, 32'h0, 32'h0);
        end
        checkOutput("wait3.h5", 1'b0, 32'h0, 1'b1, 32'hCAFE_0001, 32'h4);
        applyStimulus(0, 1, 0, 32'h0, 32'h0);
        checkOutput("wait3.next", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);

        // Redirect during a pending request, then a redirect overriding another.
        do_reset("disc");
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 1, 32'h9999_9999, 32'h10);
        checkOutput("disc.c2", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 32'h43);
        checkOutput("disc.c3", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        checkOutput("disc.c4", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        applyStimulus(0, 0, 1, 32'hDEAD_BEEF, 32'h0);
        checkOutput("disc.c5", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 32'h300);
        checkOutput("disc.c6", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 32'h500);
        checkOutput("disc.c7", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
        applyStimulus(0, 0, 1, 32'hBAD0_BAD0, 32'h0);
        checkOutput("disc.c8", 1'b1, 32'h500, 1'b0, 32'h0, 32'h0);
        applyStimulus(0, 0, 1, 32'h5555_5555, 32'h0);
        checkOutput("disc.c9", 1'b0, 32'h0, 1'b1, 32'h5555_5555, 32'h504);

        // PC wrap at the top of the address space.
        do_reset("wrap");
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 1, 32'h0, 32'hFFFF_FFFF);
        checkOutput("wrap.req", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        applyStimulus(0, 0, 1, 32'hABCD_1234, 32'h0);
        checkOutput("wrap.hold", 1'b0, 32'h0, 1'b1, 32'hABCD_1234, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 32'h0);
        checkOutput("wrap.next", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        // Asynchronous reset in the middle of a request.
        do_reset("arst");
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 1, 32'h0, 32'h24);
        checkOutput("arst.req", 1'b1, 32'h24, 1'b0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst.async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("arst.async.addr", IMem_Addr, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("arst.boot", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        checkOutput("arst.restart", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        // Randomized traffic against the reference model.
        do_reset("rand");
        for (int n = 0; n < 3000; n++) begin
            bit          r_src;
            bit          r_wr;
            bit          r_rdy;
            logic [31:0] r_tgt;
            checkOutput($sformatf("rand%0d", n), m_req, m_req_addr, m_valid,
                        m_valid ? m_instr : 32'h0, m_valid ? m_pc4 : 32'h0);
            r_src = ($urandom_range(0, 99) < 15);
            r_wr  = ($urandom_range(0, 99) < 50);
            r_rdy = ($urandom_range(0, 99) < 45);
            r_tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFD : $urandom();
            applyStimulus(r_src, r_wr, r_rdy, $urandom(), r_tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage front end. Owns the program counter, issues requests to a variable-latency instruction memory and holds the fetched word. It presents `IF_PCplusFour` / `IF_Instruction` to the IF/ID pipeline register together with a valid flag. Redirects from ID (branch/jump taken) discard the fetch in flight. It is the producer side of the IF/ID interface; the hazard unit consumes `IF_Valid` and `Fetch_Stall`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `NOP_INSTR`, 32'h0000_0000, value of `IF_Instruction` whenever `IF_Valid`=0
- `clk` in 1: single clock, all state on posedge
- `rst_n` in 1: reset, asynchronous, active-low
- `PCWrite` in 1: 1 = ID accepts the held instruction this cycle; 0 = stall
- `PCSrc` in 1: redirect request from ID
- `BranchTarget` in 32: redirect address; bits [1:0] ignored, forced to 0
- `IMem_Req` out 1: memory request, held high until `IMem_Ready`
- `IMem_Addr` out 32: request address, stable while `IMem_Req`=1 and `IMem_Ready`=0
- `IMem_Ready` in 1: `IMem_RData` valid this cycle; completes the request
- `IMem_RData` in 32: instruction word
- `IF_PCplusFour` out 32: address of held instruction + 4
- `IF_Instruction` out 32: held instruction
- `IF_Valid` out 1: held instruction is valid
- `Fetch_Stall` out 1: 1 when not `IF_Valid`; the hazard unit must then insert a bubble into IF/ID (`ID_Flush`)

## Operation
- States: BOOT, FETCH, HOLD, DISCARD. Registers: `PC`, `AddrHold`, `InstrBuf`, `PcPlus4Buf`.
- Reset (async, `rst_n`=0):
  - State BOOT, `PC`=`RESET_PC`.
  - `InstrBuf`=`NOP_INSTR`, `PcPlus4Buf`=0.
  - All outputs: `IMem_Req`=0, `IF_Valid`=0, `Fetch_Stall`=1, `IF_Instruction`=`NOP_INSTR`, `IF_PCplusFour`=0, `IMem_Addr`=`RESET_PC`.
- BOOT: no request; next state FETCH.
- FETCH:
  - Outputs: `IMem_Req`=1, `IMem_Addr`=`PC`.
  - Priority, evaluated each cycle:
    1. `PCSrc` with `IMem_Ready`: drop the data, `PC`<=target, stay FETCH.
    2. `PCSrc` without `IMem_Ready`: `AddrHold`<=`PC`, `PC`<=target, go to DISCARD.
    3. `IMem_Ready`: `InstrBuf`<=`IMem_RData`, `PcPlus4Buf`<=`PC`+4, go to HOLD.
    4. Otherwise: wait in FETCH.
- HOLD:
  - Outputs: `IF_Valid`=1, `IMem_Req`=0.
  - `PCSrc`: `PC`<=target, `IF_Valid` drops next cycle, go to FETCH. This has priority over `PCWrite`.
  - Else `PCWrite`: instruction consumed, `PC`<=`PC`+4, go to FETCH.
  - Else: hold, outputs unchanged.
- DISCARD:
  - Outputs: `IMem_Req`=1, `IMem_Addr`=`AddrHold`. Memory protocol forbids changing the address mid-request.
  - `IMem_Ready`: data dropped, go to FETCH.
  - `PCSrc` in DISCARD: `PC`<=new target. A later redirect overrides an earlier one.
- `PCWrite` is ignored outside HOLD.
- Arithmetic: `PC`+4 is 32-bit modulo. 32'hFFFF_FFFC wraps to 0, no flag.
- Outside HOLD, `IF_Instruction`=`NOP_INSTR` and `IF_PCplusFour`=0.

## Timing
- Zero-wait memory (`IMem_Ready` in the first FETCH cycle): the instruction is valid 1 cycle after the request. Peak throughput is 1 instruction per 2 cycles.
- An N-wait memory adds N cycles in FETCH.
- First request is in cycle 1 after `rst_n` deasserts; BOOT occupies cycle 0.
- Consumption handshake: `IF_Valid` && `PCWrite` && !`PCSrc`. IF/ID captures on that same edge, so `IF_ID_Write` = `PCWrite` & `IF_Valid`.
- Redirect latency: the target address appears on `IMem_Addr` the cycle after `PCSrc`. From DISCARD it appears the cycle after `IMem_Ready`.
- `rst_n` asserted mid-request: the request is abandoned immediately and `IMem_Req` goes to 0 asynchronously. The memory must tolerate an aborted request.

## Structure
- Shared package `pipeline_pkg`: fetch state enum (BOOT/FETCH/HOLD/DISCARD), `NOP_INSTR` default, `RESET_PC` default, `WORD_BYTES`=4.
- Optional sub-module `pc_reg`: PC register with async reset, load-target and increment controls. Everything else stays flat.

## Test plan
- Reset then zero-wait memory returning 32'h2008_0005 at addr 0: `IMem_Req` at cycle 1 with addr 0. Cycle 2: `IF_Valid`=1, `IF_Instruction`=32'h2008_0005, `IF_PCplusFour`=4. With `PCWrite`=1, next `IMem_Addr`=4.
- 3-wait memory with `PCWrite` held 0 for 5 cycles in HOLD: `IMem_Addr` is stable for 4 cycles. Outputs are frozen in HOLD and there is no new request until `PCWrite`=1.
- `PCSrc`=1, `BranchTarget`=32'h0000_0043, asserted during a pending request at 0x10: DISCARD keeps addr 0x10 until Ready, the data is never valid, and the next request goes to 0x40.
- `PCSrc` and `PCWrite` both 1 in HOLD at PC 0x8, target 0x100: next request is to 0x100 and `IF_Valid`=0.
- PC=32'hFFFF_FFFC fetched and consumed: `IF_PCplusFour`=0 and the next request is to addr 0.
- `rst_n` pulsed low mid-FETCH at 0x24: `IMem_Req` goes to 0 asynchronously and fetch restarts at `RESET_PC`.
